// File: rtl/sdf_fft_pkg.sv
// Shared fixed-point constants, the 64-point twiddle table and the round/saturate helpers
// for the SDF FFT datapath. Pure constants and functions, no state.
package sdf_fft_pkg;

    localparam int DATA_W_DEF = 14;
    localparam int TW_W_DEF   = 13;
    localparam int TW_TAB_N   = 64;

    // W_64^k = cos(2*pi*k/64) - j*sin(2*pi*k/64), k = 0..31, scaled by 2^11 and floored.
    // Every smaller power-of-two frame uses a decimation of this table (stride 64/N).
    localparam int TW64_RE [TW_TAB_N/2] = '{
         2048,  2038,  2008,  1959,  1892,  1806,  1702,  1583,
         1448,  1299,  1137,   965,   783,   594,   399,   200,
            0,  -201,  -400,  -595,  -784,  -966, -1138, -1300,
        -1449, -1584, -1703, -1807, -1893, -1960, -2009, -2039
    };
    localparam int TW64_IM [TW_TAB_N/2] = '{
            0,  -201,  -400,  -595,  -784,  -966, -1138, -1300,
        -1449, -1584, -1703, -1807, -1893, -1960, -2009, -2039,
        -2048, -2039, -2009, -1960, -1893, -1807, -1703, -1584,
        -1449, -1300, -1138,  -966,  -784,  -595,  -400,  -201
    };

    // Round half-up then drop 'frac' fractional bits.
    function automatic logic signed [63:0] round_shift(input logic signed [63:0] acc,
                                                       input int frac);
        return (acc + (64'sd1 <<< (frac - 1))) >>> frac;
    endfunction

    function automatic logic signed [63:0] sat_val(input logic signed [63:0] acc,
                                                   input int frac, input int dw);
        logic signed [63:0] r, hi, lo;
        r  = round_shift(acc, frac);
        hi = (64'sd1 <<< (dw - 1)) - 64'sd1;
        lo = -(64'sd1 <<< (dw - 1));
        if (r > hi)      return hi;
        else if (r < lo) return lo;
        else             return r;
    endfunction

    function automatic logic sat_flag(input logic signed [63:0] acc,
                                      input int frac, input int dw);
        logic signed [63:0] r, hi, lo;
        r  = round_shift(acc, frac);
        hi = (64'sd1 <<< (dw - 1)) - 64'sd1;
        lo = -(64'sd1 <<< (dw - 1));
        return (r > hi) || (r < lo);
    endfunction

endpackage

// File: rtl/twiddle_rom.sv
// Combinational twiddle lookup W_N^idx for the first half of an N-point frame.
// Zero latency, no flow control.
module twiddle_rom
    import sdf_fft_pkg::*;
#(
    parameter int N_POINT = 8,
    parameter int TW_W    = TW_W_DEF,
    parameter int CNT_W   = $clog2(N_POINT)
) (
    input  logic [CNT_W-2:0]        idx_i,
    output logic signed [TW_W-1:0]  tw_real_o,
    output logic signed [TW_W-1:0]  tw_imag_o
);

    localparam int STRIDE = TW_TAB_N / N_POINT;
    localparam int K_W    = $clog2(TW_TAB_N / 2);

    logic [K_W-1:0] k;

    always_comb begin
        k         = K_W'(int'(idx_i) * STRIDE);
        tw_real_o = TW_W'(TW64_RE[k]);
        tw_imag_o = TW_W'(TW64_IM[k]);
    end

endmodule

// File: rtl/sdf_twiddle_mult.sv
// SDF radix-2 twiddle multiplier: first half-frame x W_N^idx (rounded, saturated), second half bypassed.
// Fixed 3-cycle latency, free-running pipeline, no backpressure.
module sdf_twiddle_mult
    import sdf_fft_pkg::*;
#(
    parameter int DATA_W  = DATA_W_DEF,
    parameter int TW_W    = TW_W_DEF,
    parameter int N_POINT = 8,
    parameter int CNT_W   = $clog2(N_POINT)
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      frame_start,
    input  logic                      in_valid,
    input  logic signed [DATA_W-1:0]  in_real,
    input  logic signed [DATA_W-1:0]  in_imag,
    output logic                      out_valid,
    output logic signed [DATA_W-1:0]  out_real,
    output logic signed [DATA_W-1:0]  out_imag,
    output logic                      out_mult,
    output logic                      out_sat
);

    localparam int P_W   = DATA_W + TW_W;
    localparam int ACC_W = P_W + 1;
    localparam int FRAC  = TW_W - 2;

    logic [CNT_W-1:0] idx_q, idx_d, cur_idx;
    logic             is_mult;
    logic signed [TW_W-1:0] br_c, bi_c;

    // frame_start overrides the running index for the sample presented with it.
    always_comb begin
        cur_idx = frame_start ? '0 : idx_q;
        idx_d   = idx_q;
        if (in_valid)
            idx_d = cur_idx + CNT_W'(1);
        else if (frame_start)
            idx_d = '0;
        is_mult = ~cur_idx[CNT_W-1];
    end

    twiddle_rom #(
        .N_POINT (N_POINT),
        .TW_W    (TW_W),
        .CNT_W   (CNT_W)
    ) u_rom (
        .idx_i     (cur_idx[CNT_W-2:0]),
        .tw_real_o (br_c),
        .tw_imag_o (bi_c)
    );

    logic                     v1_q, mult1_q;
    logic signed [DATA_W-1:0] ar1_q, ai1_q;
    logic signed [TW_W-1:0]   br1_q, bi1_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            idx_q   <= '0;
            v1_q    <= 1'b0;
            mult1_q <= 1'b0;
            ar1_q   <= '0;
            ai1_q   <= '0;
            br1_q   <= '0;
            bi1_q   <= '0;
        end else begin
            idx_q <= idx_d;
            v1_q  <= in_valid;
            if (in_valid) begin
                mult1_q <= is_mult;
                ar1_q   <= in_real;
                ai1_q   <= in_imag;
                br1_q   <= br_c;
                bi1_q   <= bi_c;
            end
        end
    end

    logic                     v2_q, mult2_q;
    logic signed [DATA_W-1:0] ar2_q, ai2_q;
    logic signed [P_W-1:0]    prr_q, pii_q, pri_q, pir_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            v2_q    <= 1'b0;
            mult2_q <= 1'b0;
            ar2_q   <= '0;
            ai2_q   <= '0;
            prr_q   <= '0;
            pii_q   <= '0;
            pri_q   <= '0;
            pir_q   <= '0;
        end else begin
            v2_q <= v1_q;
            if (v1_q) begin
                mult2_q <= mult1_q;
                ar2_q   <= ar1_q;
                ai2_q   <= ai1_q;
                prr_q   <= P_W'(ar1_q) * P_W'(br1_q);
                pii_q   <= P_W'(ai1_q) * P_W'(bi1_q);
                pri_q   <= P_W'(ar1_q) * P_W'(bi1_q);
                pir_q   <= P_W'(ai1_q) * P_W'(br1_q);
            end
        end
    end

    // One guard bit on the sums: |re|,|im| can reach 2 * 2^(P_W-1).
    logic signed [ACC_W-1:0] re_sum, im_sum;
    logic signed [63:0]      re_ext, im_ext;

    always_comb begin
        re_sum = ACC_W'(prr_q) - ACC_W'(pii_q);
        im_sum = ACC_W'(pri_q) + ACC_W'(pir_q);
        re_ext = 64'(re_sum);
        im_ext = 64'(im_sum);
    end

    logic                     out_valid_q, out_mult_q, out_sat_q;
    logic signed [DATA_W-1:0] out_real_q, out_imag_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid_q <= 1'b0;
            out_real_q  <= '0;
            out_imag_q  <= '0;
            out_mult_q  <= 1'b0;
            out_sat_q   <= 1'b0;
        end else begin
            out_valid_q <= v2_q;
            if (v2_q) begin
                if (mult2_q) begin
                    out_real_q <= DATA_W'(sat_val(re_ext, FRAC, DATA_W));
                    out_imag_q <= DATA_W'(sat_val(im_ext, FRAC, DATA_W));
                    out_mult_q <= 1'b1;
                    out_sat_q  <= sat_flag(re_ext, FRAC, DATA_W) | sat_flag(im_ext, FRAC, DATA_W);
                end else begin
                    out_real_q <= ar2_q;
                    out_imag_q <= ai2_q;
                    out_mult_q <= 1'b0;
                    out_sat_q  <= 1'b0;
                end
            end
        end
    end

    assign out_valid = out_valid_q;
    assign out_real  = out_real_q;
    assign out_imag  = out_imag_q;
    assign out_mult  = out_mult_q;
    assign out_sat   = out_sat_q;

endmodule

// File: tb/tb_sdf_twiddle_mult.sv
// Directed + gapped-random bench for sdf_twiddle_mult at N = 8 with a queue scoreboard.
module tb_sdf_twiddle_mult;

    localparam int DATA_W  = 14;
    localparam int TW_W    = 13;
    localparam int N_POINT = 8;

    localparam int TWR [4] = '{2048, 1448, 0, -1449};
    localparam int TWI [4] = '{0, -1449, -2048, -1449};

    logic clk = 1'b0;
    logic rst_n;
    logic frame_start, in_valid;
    logic signed [DATA_W-1:0] in_real, in_imag;
    logic out_valid, out_mult, out_sat;
    logic signed [DATA_W-1:0] out_real, out_imag;

    always #5 clk = ~clk;

    sdf_twiddle_mult #(
        .DATA_W  (DATA_W),
        .TW_W    (TW_W),
        .N_POINT (N_POINT)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .frame_start (frame_start),
        .in_valid    (in_valid),
        .in_real     (in_real),
        .in_imag     (in_imag),
        .out_valid   (out_valid),
        .out_real    (out_real),
        .out_imag    (out_imag),
        .out_mult    (out_mult),
        .out_sat     (out_sat)
    );

    typedef struct {
        int re;
        int im;
        bit mult;
        bit sat;
        int cyc;
    } exp_t;

    exp_t sbq[$];
    int checks = 0;
    int errors = 0;
    int cyc    = 0;
    int bidx   = 0;
    int n_in   = 0;
    int n_out  = 0;
    integer prev_re = 0, prev_im = 0, prev_mult = 0, prev_sat = 0;

    task automatic chk(input string tag, input integer obs, input integer exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    function automatic exp_t mk(input int re, input int im, input bit m, input bit s);
        exp_t e;
        e.re = re; e.im = im; e.mult = m; e.sat = s; e.cyc = 0;
        return e;
    endfunction

    function automatic longint clamp(input longint v, output bit s);
        s = 1'b0;
        if (v > 8191)  begin s = 1'b1; return 8191;  end
        if (v < -8192) begin s = 1'b1; return -8192; end
        return v;
    endfunction

    function automatic exp_t model(input int idx, input int ar, input int ai);
        exp_t e;
        longint re, im;
        bit s_re, s_im;
        if (idx < N_POINT/2) begin
            re = longint'(ar) * TWR[idx] - longint'(ai) * TWI[idx];
            im = longint'(ar) * TWI[idx] + longint'(ai) * TWR[idx];
            e.re   = int'(clamp((re + 1024) >>> 11, s_re));
            e.im   = int'(clamp((im + 1024) >>> 11, s_im));
            e.mult = 1'b1;
            e.sat  = s_re | s_im;
        end else begin
            e = mk(ar, ai, 1'b0, 1'b0);
        end
        e.cyc = 0;
        return e;
    endfunction

    function automatic int rnd();
        logic signed [DATA_W-1:0] t;
        t = DATA_W'($urandom_range(0, (1 << DATA_W) - 1));
        return int'(t);
    endfunction

    task automatic check_out();
        exp_t e;
        if (out_valid === 1'b1) begin
            n_out++;
            if (sbq.size() == 0) begin
                chk("spurious_out_valid", out_valid, 0);
            end else begin
                e = sbq.pop_front();
                chk("latency",  cyc,      e.cyc);
                chk("out_real", out_real, e.re);
                chk("out_imag", out_imag, e.im);
                chk("out_mult", out_mult, e.mult);
                chk("out_sat",  out_sat,  e.sat);
            end
            prev_re = out_real; prev_im = out_imag; prev_mult = out_mult; prev_sat = out_sat;
        end else begin
            chk("idle_valid", out_valid, 0);
            chk("hold_real",  out_real,  prev_re);
            chk("hold_imag",  out_imag,  prev_im);
            chk("hold_mult",  out_mult,  prev_mult);
            chk("hold_sat",   out_sat,   prev_sat);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
        check_out();
    endtask

    task automatic drive(input bit fs, input bit v, input int re, input int im,
                         input bit use_model, input exp_t de);
        int   use_idx;
        exp_t e;
        frame_start = fs;
        in_valid    = v;
        in_real     = DATA_W'(re);
        in_imag     = DATA_W'(im);
        if (v) begin
            use_idx = fs ? 0 : bidx;
            e = use_model ? model(use_idx, re, im) : de;
            e.cyc = cyc + 3;
            sbq.push_back(e);
            n_in++;
            bidx = (use_idx + 1) % N_POINT;
        end else if (fs) begin
            bidx = 0;
        end
        tick();
    endtask

    task automatic step(input bit fs, input bit v, input int re, input int im);
        drive(fs, v, re, im, 1'b1, mk(0, 0, 1'b0, 1'b0));
    endtask

    initial begin
        rst_n = 1'b0; frame_start = 1'b0; in_valid = 1'b0; in_real = '0; in_imag = '0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_valid", out_valid, 0);
        chk("rst_real",  out_real,  0);
        chk("rst_imag",  out_imag,  0);
        chk("rst_mult",  out_mult,  0);
        chk("rst_sat",   out_sat,   0);
        rst_n = 1'b1;

        // Frame 1: hand-computed expectations.
        drive(1, 1, 1000, -300,  0, mk(1000, -300, 1, 0));
        drive(0, 1, 4096, 0,     0, mk(2896, -2898, 1, 0));
        drive(0, 1, 1000, 500,   0, mk(500, -1000, 1, 0));
        drive(0, 1, 8191, -8192, 0, mk(-8192, 1, 1, 1));
        for (int i = 0; i < 4; i++) drive(0, 1, 123, -45, 0, mk(123, -45, 0, 0));
        // Counter wrap: next sample is idx 0 again.
        drive(0, 1, 1000, -300, 0, mk(1000, -300, 1, 0));
        step(0, 1, 8191, 8191);
        repeat (4) step(0, 0, rnd(), rnd());

        // Mid-frame resync with and without a valid sample.
        step(0, 1, rnd(), rnd());
        step(0, 1, rnd(), rnd());
        drive(1, 1, 500, 700, 0, mk(500, 700, 1, 0));
        step(0, 1, rnd(), rnd());
        step(1, 0, rnd(), rnd());
        drive(0, 1, 300, -200, 0, mk(300, -200, 1, 0));

        // Gapped random traffic with occasional resyncs.
        for (int i = 0; i < 60; i++)
            step($urandom_range(0, 9) == 0, $urandom_range(0, 3) != 0, rnd(), rnd());

        // Asynchronous reset with samples in flight.
        step(0, 1, rnd(), rnd());
        step(0, 1, rnd(), rnd());
        step(0, 1, rnd(), rnd());
        #1 rst_n = 1'b0;
        #1 chk("async_rst_valid", out_valid, 0);
        n_in -= sbq.size();
        sbq.delete();
        bidx = 0;
        prev_re = 0; prev_im = 0; prev_mult = 0; prev_sat = 0;
        in_valid = 1'b0; frame_start = 1'b0;
        repeat (3) tick();
        rst_n = 1'b1;

        // Counter restarts at 0 without frame_start.
        drive(0, 1, 1000, -300, 0, mk(1000, -300, 1, 0));
        for (int i = 0; i < 20; i++)
            step(1'b0, $urandom_range(0, 2) != 0, rnd(), rnd());

        repeat (6) step(0, 0, 0, 0);
        chk("drain_queue_empty", sbq.size(), 0);
        chk("valid_count", n_out, n_in);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
